// File: rtl/fifo_rd_stream_if.sv
// Valid/ready stream carrying words drained from the async_fifo read port.
// Pure wiring; master drives m_valid/m_data, slave drives m_ready.
// A word moves on any rd_clk edge where m_valid && m_ready.
interface fifo_rd_stream_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;

  modport master (output m_valid, output m_data, input m_ready);
  modport slave  (input m_valid, input m_data, output m_ready);
endinterface

// File: rtl/fifo_rd_stream.sv
// Drains async_fifo (empty/rd_en/rd_data) into a valid/ready stream via a credit-checked skid buffer.
// Latency: rd_en in cycle N -> m_valid in cycle N+RD_LATENCY+1; one word per cycle sustained.
// Backpressure: reads issue only while buffered + in-flight < BUF_DEPTH, so stalls never lose data.
// Optional FIFO_RD_STREAM_STATS_EN adds word_count and max_occupancy outputs.
module fifo_rd_stream #(
  parameter int DATA_WIDTH = 8,
  parameter int RD_LATENCY = 1
) (
  input  logic                  rd_clk,
  input  logic                  rst_n,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  fifo_rd_stream_if.master      m_if
`ifdef FIFO_RD_STREAM_STATS_EN
  ,
  output logic [31:0]                         word_count,
  output logic [$clog2(RD_LATENCY+3)-1:0]     max_occupancy
`endif
);

  // Skid depth covers the read pipeline plus one word on the output and one of slack.
  localparam int BUF_DEPTH = RD_LATENCY + 2;
  localparam int OCC_W     = $clog2(BUF_DEPTH + 1);
  localparam int PTR_W     = $clog2(BUF_DEPTH);

  logic [RD_LATENCY-1:0] issue_pipe;
  logic                  capture;
  logic                  pop;
  logic [OCC_W:0]        inflight;
  logic [OCC_W-1:0]      occupancy;
  logic [OCC_W-1:0]      occupancy_nxt;
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [DATA_WIDTH-1:0] buf_mem [BUF_DEPTH];

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // The oldest issue bit leaving the pipe marks the cycle fifo_rd_data is valid.
  assign capture = issue_pipe[RD_LATENCY-1];
  assign pop     = m_if.m_valid && m_if.m_ready;

  // Output comes straight from buffer registers; no path from fifo_rd_data.
  assign m_if.m_valid = (occupancy != '0);
  assign m_if.m_data  = buf_mem[rd_ptr];

  // Count reads already issued but not yet captured.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      inflight = inflight + (OCC_W+1)'(issue_pipe[i]);
    end
  end

  // Issue only with a guaranteed free slot; a same-cycle pop is deliberately not counted.
  assign fifo_rd_en = rst_n && !fifo_empty &&
                      (({1'b0, occupancy} + inflight) < (OCC_W+1)'(BUF_DEPTH));

  // Next occupancy from capture (push) and transfer (pop).
  always_comb begin
    occupancy_nxt = occupancy;
    case ({capture, pop})
      2'b10:   occupancy_nxt = occupancy + 1'b1;
      2'b01:   occupancy_nxt = occupancy - 1'b1;
      default: occupancy_nxt = occupancy;
    endcase
  end

  // Shift issue bits toward the capture point, one stage per read-latency cycle.
  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_pipe <= '0;
    end else begin
      issue_pipe[0] <= fifo_rd_en;
      for (int i = 1; i < RD_LATENCY; i++) begin
        issue_pipe[i] <= issue_pipe[i-1];
      end
    end
  end

  // Circular skid buffer: write at tail on capture, advance head on transfer.
  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        buf_mem[i] <= '0;
      end
    end else begin
      if (capture) begin
        buf_mem[wr_ptr] <= fifo_rd_data;
        wr_ptr          <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      occupancy <= occupancy_nxt;
    end
  end

`ifdef FIFO_RD_STREAM_STATS_EN
  // Transfer counter (wraps) and occupancy high-water mark since reset.
  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      word_count    <= '0;
      max_occupancy <= '0;
    end else begin
      if (pop) begin
        word_count <= word_count + 32'd1;
      end
      if (occupancy_nxt > max_occupancy) begin
        max_occupancy <= occupancy_nxt;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed + randomized bench for fifo_rd_stream with a behavioural async_fifo read port.
// Issued words go to a scoreboard queue; each stream transfer pops and compares.
// Reports one summary line with assertion and failure counts.
module tb_fifo_rd_stream;
  localparam int DW     = 8;
  localparam int RD_LAT = 1;
  localparam int BUF_D  = RD_LAT + 2;
  localparam int OCC_W  = $clog2(BUF_D + 1);

  logic          rd_clk = 1'b0;
  logic          rst_n;
  logic          fifo_empty;
  logic          fifo_rd_en;
  logic [DW-1:0] fifo_rd_data;
`ifdef FIFO_RD_STREAM_STATS_EN
  logic [31:0]      word_count;
  logic [OCC_W-1:0] max_occupancy;
`endif

  fifo_rd_stream_if #(.DATA_WIDTH(DW)) m_if ();

  fifo_rd_stream #(.DATA_WIDTH(DW), .RD_LATENCY(RD_LAT)) dut (
    .rd_clk       (rd_clk),
    .rst_n        (rst_n),
    .fifo_empty   (fifo_empty),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_rd_data (fifo_rd_data),
    .m_if         (m_if)
`ifdef FIFO_RD_STREAM_STATS_EN
    ,
    .word_count    (word_count),
    .max_occupancy (max_occupancy)
`endif
  );

  always #5 rd_clk = ~rd_clk;

  logic [DW-1:0] src_q [$];
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] rd_pipe [RD_LAT];
  int            n_checks = 0;
  int            n_fail   = 0;
  int            cyc      = 0;
  int            n_issued, n_deliv, n_since_rst, first_v, last_v, issue_cyc;
  bit            hold_empty, got_first;
  logic          prev_v, prev_r;
  logic [DW-1:0] prev_d, first_word, e;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic clear_model();
    src_q.delete();
    exp_q.delete();
    for (int i = 0; i < RD_LAT; i++) rd_pipe[i] = '0;
    prev_v = 1'b0;
    prev_r = 1'b0;
    prev_d = '0;
    n_since_rst = 0;
  endtask

  task automatic clear_counts();
    n_issued  = 0;
    n_deliv   = 0;
    first_v   = -1;
    last_v    = -1;
    issue_cyc = -1;
    got_first = 1'b0;
  endtask

  // One rd_clk cycle: drive at negedge, sample #1 later, update model, wait next negedge.
  task automatic step();
    fifo_empty   = (src_q.size() == 0) || hold_empty;
    fifo_rd_data = rd_pipe[RD_LAT-1];
    #1;
    cyc++;
    if (rst_n) begin
      if (fifo_empty) check("rd_en_while_empty", fifo_rd_en, 0);
      if (prev_v && !prev_r) begin
        check("stall_valid", m_if.m_valid, 1);
        check("stall_data", m_if.m_data, prev_d);
      end
      for (int i = RD_LAT-1; i > 0; i--) rd_pipe[i] = rd_pipe[i-1];
      if (fifo_rd_en) begin
        rd_pipe[0] = src_q.pop_front();
        exp_q.push_back(rd_pipe[0]);
        n_issued++;
        issue_cyc = cyc;
      end
      if (m_if.m_valid) begin
        if (first_v < 0) first_v = cyc;
        last_v = cyc;
      end
      if (m_if.m_valid && m_if.m_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("m_data", m_if.m_data, e);
        end
        if (!got_first) begin
          got_first  = 1'b1;
          first_word = m_if.m_data;
        end
        n_deliv++;
        n_since_rst++;
      end
      if (exp_q.size() > BUF_D) check("outstanding_le_depth", exp_q.size(), BUF_D);
      prev_v = m_if.m_valid;
      prev_r = m_if.m_ready;
      prev_d = m_if.m_data;
    end
    @(negedge rd_clk);
  endtask

  initial begin
    int guard;
    rst_n         = 1'b0;
    fifo_empty    = 1'b0;
    fifo_rd_data  = '0;
    m_if.m_ready  = 1'b0;
    hold_empty    = 1'b0;
    clear_model();
    clear_counts();

    // Reset values with the FIFO claiming data.
    repeat (2) @(negedge rd_clk);
    #1;
    check("rst_rd_en", fifo_rd_en, 0);
    check("rst_m_valid", m_if.m_valid, 0);
    check("rst_m_data", m_if.m_data, 0);
`ifdef FIFO_RD_STREAM_STATS_EN
    check("rst_word_count", word_count, 0);
    check("rst_max_occ", max_occupancy, 0);
`endif
    @(negedge rd_clk);
    rst_n = 1'b1;

    // Empty FIFO after release: no reads.
    repeat (20) step();
    check("idle_issues", n_issued, 0);
    check("idle_valid", m_if.m_valid, 0);

    // Single word latency.
    clear_counts();
    m_if.m_ready = 1'b1;
    src_q.push_back(8'hAB);
    repeat (8) step();
    check("single_issues", n_issued, 1);
    check("single_latency", first_v - issue_cyc, RD_LAT + 1);
    check("single_valid_cycles", last_v - first_v + 1, 1);
    check("single_deliv", n_deliv, 1);
    check("single_word", first_word, 8'hAB);
    check("single_valid_after", m_if.m_valid, 0);

    // Streaming 16 words with no gaps.
    clear_counts();
    for (int i = 0; i < 16; i++) src_q.push_back(DW'(i));
    repeat (25) step();
    check("stream_issues", n_issued, 16);
    check("stream_deliv", n_deliv, 16);
    check("stream_no_gaps", last_v - first_v + 1, 16);

    // Backpressure: only BUF_D reads while stalled, then lossless drain.
    clear_counts();
    m_if.m_ready = 1'b0;
    for (int i = 0; i < 16; i++) src_q.push_back(DW'(i));
    repeat (20) step();
    check("bp_issues", n_issued, BUF_D);
    check("bp_valid", m_if.m_valid, 1);
    check("bp_data", m_if.m_data, 0);
`ifdef FIFO_RD_STREAM_STATS_EN
    check("bp_max_occ", max_occupancy, BUF_D);
`endif
    m_if.m_ready = 1'b1;
    guard = 0;
    while ((src_q.size() != 0 || exp_q.size() != 0) && guard < 200) begin
      step();
      guard++;
    end
    check("bp_drain_timeout", guard < 200, 1);
    check("bp_deliv", n_deliv, 16);
    check("bp_issues_total", n_issued, 16);
`ifdef FIFO_RD_STREAM_STATS_EN
    check("bp_word_count", word_count, n_since_rst);
`endif

    // Random ready and random empty gating over 1000 words.
    clear_counts();
    for (int i = 0; i < 1000; i++) src_q.push_back(DW'($urandom_range(0, 255)));
    guard = 0;
    while (n_deliv < 1000 && guard < 20000) begin
      m_if.m_ready = ($urandom_range(0, 1) == 1);
      hold_empty   = ($urandom_range(0, 3) == 0);
      step();
      guard++;
    end
    hold_empty = 1'b0;
    check("rand_deliv", n_deliv, 1000);
    check("rand_leftover", exp_q.size(), 0);

    // Reset mid-stream with words in flight / buffered.
    clear_counts();
    m_if.m_ready = 1'b0;
    for (int i = 0; i < 4; i++) src_q.push_back(DW'(8'h10 + i));
    repeat (3) step();
    check("mid_outstanding", exp_q.size() >= 2, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", m_if.m_valid, 0);
    check("mid_rst_rd_en", fifo_rd_en, 0);
`ifdef FIFO_RD_STREAM_STATS_EN
    check("mid_rst_word_count", word_count, 0);
`endif
    clear_model();
    clear_counts();
    @(negedge rd_clk);
    @(negedge rd_clk);
    rst_n = 1'b1;
    m_if.m_ready = 1'b1;
    src_q.push_back(8'h5A);
    repeat (10) step();
    check("post_rst_got", got_first, 1);
    check("post_rst_first", first_word, 8'h5A);
    check("post_rst_deliv", n_deliv, 1);
`ifdef FIFO_RD_STREAM_STATS_EN
    check("post_rst_word_count", word_count, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
